seg7_scan_display: RTL and testbench

- Downstream consumer of the processor's 16-bit test_value output. Drives a 4-digit, common-anode, multiplexed seven-segment display on the FPGA board.
- Samples the value, scans the four hex digits with a programmable refresh period, and inserts an anti-ghosting blank window at the start of each digit slot.
- Emits a one-cycle pulse whenever the displayed value changes.

---
 rtl/seg7_scan_display_if.sv | 20 ++
 rtl/seg7_scan_display.sv | 125 ++++++++++++
 tb/tb_seg7_scan_display.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seg7_scan_display_if.sv
// Display-side signal bundle for seg7_scan_display: value/freeze in,
// anode/segment/decimal-point drives and change pulse out.
interface seg7_scan_display_if;
    logic [15:0] value;
    logic        freeze;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        update_pulse;

    modport master (
        output value, freeze,
        input  an, seg, dp, update_pulse
    );

    modport slave (
        input  value, freeze,
        output an, seg, dp, update_pulse
    );
endinterface

// File: rtl/seg7_scan_display.sv
// 4-digit common-anode hex scanner with per-slot blank window and change pulse.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits 3..1.
module seg7_scan_display #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input logic               clk,
    input logic               reset,
    seg7_scan_display_if.slave bus
);
    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LP_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] LP_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_disp_q;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_update_pulse;

    logic          w_blank;
    logic          w_suppress;
    logic [3:0]    w_nib;
    logic [6:0]    w_hex;
    logic [3:0]    w_an_next;
    logic [6:0]    w_seg_next;

    // A zero-length blank window must not produce a constant compare.
    generate
        if (BLANK_CYCLES == 0) begin : g_noblank
            assign w_blank = 1'b0;
        end else begin : g_blank
            assign w_blank = (r_cnt < LP_BLANK);
        end
    endgenerate

    always_comb begin
        w_nib = r_disp_q[3:0];
        case (r_idx)
            2'd0: w_nib = r_disp_q[3:0];
            2'd1: w_nib = r_disp_q[7:4];
            2'd2: w_nib = r_disp_q[11:8];
            2'd3: w_nib = r_disp_q[15:12];
            default: w_nib = r_disp_q[3:0];
        endcase
    end

    always_comb begin
        w_suppress = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (r_idx)
            2'd3: w_suppress = (r_disp_q[15:12] == 4'h0);
            2'd2: w_suppress = (r_disp_q[15:8] == 8'h00);
            2'd1: w_suppress = (r_disp_q[15:4] == 12'h000);
            default: w_suppress = 1'b0;
        endcase
`endif
    end

    always_comb begin
        w_hex = 7'b1111111;
        case (w_nib)
            4'h0: w_hex = 7'b1000000;
            4'h1: w_hex = 7'b1111001;
            4'h2: w_hex = 7'b0100100;
            4'h3: w_hex = 7'b0110000;
            4'h4: w_hex = 7'b0011001;
            4'h5: w_hex = 7'b0010010;
            4'h6: w_hex = 7'b0000010;
            4'h7: w_hex = 7'b1111000;
            4'h8: w_hex = 7'b0000000;
            4'h9: w_hex = 7'b0010000;
            4'hA: w_hex = 7'b0001000;
            4'hB: w_hex = 7'b0000011;
            4'hC: w_hex = 7'b1000110;
            4'hD: w_hex = 7'b0100001;
            4'hE: w_hex = 7'b0000110;
            4'hF: w_hex = 7'b0001110;
            default: w_hex = 7'b1111111;
        endcase
    end

    always_comb begin
        w_an_next  = '1;
        w_seg_next = '1;
        if (!w_blank && !w_suppress) begin
            w_an_next  = ~(4'b0001 << r_idx);
            w_seg_next = w_hex;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt          <= '0;
            r_idx          <= '0;
            r_disp_q       <= '0;
            r_an           <= '1;
            r_seg          <= '1;
            r_update_pulse <= 1'b0;
        end else begin
            if (r_cnt == LP_LAST) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (!bus.freeze) begin
                r_disp_q       <= bus.value;
                r_update_pulse <= (bus.value != r_disp_q);
            end else begin
                r_update_pulse <= 1'b0;
            end

            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign bus.an           = r_an;
    assign bus.seg          = r_seg;
    assign bus.dp           = 1'b1;
    assign bus.update_pulse = r_update_pulse;
endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: a time-based reference model pushes the
// expected outputs of every edge; a monitor pops and compares after each edge.
module tb_seg7_scan_display;
    localparam int unsigned R = 8;
    localparam int unsigned B = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg7_scan_display_if bus ();

    seg7_scan_display #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       pulse;
    } exp_t;

    exp_t exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [6:0] hex_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference state: edges since reset and the value currently held.
    int unsigned m_t;
    logic [15:0] m_disp;

    function automatic exp_t model_out(input int unsigned t, input logic [15:0] d);
        exp_t e;
        int unsigned cnt;
        int unsigned idx;
        bit sup;
        cnt = t % R;
        idx = (t / R) % 4;
        e.an = 4'b1111;
        e.seg = 7'b1111111;
        e.dp = 1'b1;
        e.pulse = 1'b0;
        sup = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && (d >> (4 * idx)) == 16'h0) sup = 1'b1;
`endif
        if (cnt >= B && !sup) begin
            e.an[idx] = 1'b0;
            e.seg = hex_tbl[(d >> (4 * idx)) & 16'hF];
        end
        return e;
    endfunction

    task automatic step(input logic rst, input logic [15:0] v, input logic fz);
        exp_t e;
        reset = rst;
        bus.value = v;
        bus.freeze = fz;
        if (rst) begin
            e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1, pulse: 1'b0};
            m_t = 0;
            m_disp = 16'h0;
        end else begin
            e = model_out(m_t, m_disp);
            e.pulse = !fz && (v != m_disp);
            m_t++;
            if (!fz) m_disp = v;
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("an", 32'(bus.an), 32'(e.an));
                check("seg", 32'(bus.seg), 32'(e.seg));
                check("dp", 32'(bus.dp), 32'(e.dp));
                check("update_pulse", 32'(bus.update_pulse), 32'(e.pulse));
            end
        end
    end

    logic [15:0] pool [8] = '{16'h1234, 16'hABCD, 16'h0042, 16'h0000,
                              16'h000F, 16'h0100, 16'hFFFF, 16'h8001};

    initial begin : stim
        logic [15:0] v;
        logic fz;
        m_t = 0;
        m_disp = 16'h0;
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0, 1'b0);
        for (int i = 0; i < 70; i++) step(1'b0, 16'h1234, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 16'hABCD, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 16'h1234, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 16'h0042, 1'b0);
        for (int i = 0; i < 64 && !(((m_t / R) % 4) == 2 && (m_t % R) == 3); i++)
            step(1'b0, 16'h1234, 1'b0);
        step(1'b1, 16'h1234, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 16'h1234, 1'b0);
        v = 16'h1234;
        fz = 1'b0;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 15) == 0) v = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : 16'($urandom);
            if ($urandom_range(0, 19) == 0) fz = ~fz;
            step($urandom_range(0, 249) == 0, v, fz);
        end
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
